sys_debug_ctrl: RTL and testbench

Run-control and observation block for the MIPS system top. It replaces the free-running clock and the combinational LED mux.
- Gates the core through a clock-enable using run/halt/single-step commands and PC breakpoints.
- Freezes a snapshot of all probe channels on every halt.
- Drives a registered, parametrised LED window for any probe.
- Sits between the board switches/keys and the processor datapath.

---
 rtl/sys_dbg_pkg.sv | 32 +++
 rtl/sys_debug_ctrl_bp_cmp.sv | 36 +++
 rtl/sys_debug_ctrl.sv | 169 ++++++++++++++++
 tb/tb_sys_debug_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_dbg_pkg.sv
// Shared types, default widths and the LED slice helper for the debug controller.
package sys_dbg_pkg;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } dbg_state_e;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_LED_W   = 18;
    localparam int DEF_NUM_CH  = 8;
    localparam int DEF_SEL_W   = 4;
    localparam int DEF_NUM_BP  = 2;
    localparam int SLICE_MAX_W = 64;

    // Callers zero-extend the channel, so bits above DATA_W come back as zero.
    function automatic logic [SLICE_MAX_W-1:0] slice_extract(
        input logic [SLICE_MAX_W-1:0] ch,
        input logic                   sel,
        input int                     led_w
    );
        logic [SLICE_MAX_W-1:0] res_s;
        if (sel) begin
            res_s = ch >> led_w;
        end else begin
            res_s = ch;
        end
        return res_s;
    endfunction

endpackage

// File: rtl/sys_debug_ctrl_bp_cmp.sv
// PC breakpoint comparators with a lowest-index priority encoder (combinational).
module sys_debug_ctrl_bp_cmp
    import sys_dbg_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_BP = DEF_NUM_BP,
    parameter int SEL_W  = DEF_SEL_W
) (
    input  logic [NUM_BP-1:0]        bp_en,
    input  logic [NUM_BP*DATA_W-1:0] bp_addr,
    input  logic [DATA_W-1:0]        pc_in,
    output logic                     match,
    output logic [SEL_W-1:0]         idx
);

    logic             match_s;
    logic [SEL_W-1:0] idx_s;

    // Scan from the top down so the lowest matching index is the one that sticks.
    always_comb begin
        match_s = 1'b0;
        idx_s   = {SEL_W{1'b0}};
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (bp_en[i] && (pc_in == bp_addr[i*DATA_W +: DATA_W])) begin
                match_s = 1'b1;
                idx_s   = SEL_W'(i);
            end else begin
                match_s = match_s;
            end
        end
    end

    assign match = match_s;
    assign idx   = idx_s;

endmodule

// File: rtl/sys_debug_ctrl.sv
// Run/halt/step control, breakpoint handling, halt snapshot and LED window for the core.
module sys_debug_ctrl
    import sys_dbg_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LED_W  = DEF_LED_W,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int SEL_W  = DEF_SEL_W,
    parameter int NUM_BP = DEF_NUM_BP
) (
    input  logic                     SYS_clk,
    input  logic                     SYS_reset,
    input  logic                     dbg_run,
    input  logic                     dbg_halt,
    input  logic                     dbg_step,
    input  logic [NUM_BP-1:0]        bp_en,
    input  logic [NUM_BP*DATA_W-1:0] bp_addr,
    input  logic [DATA_W-1:0]        pc_in,
    input  logic [NUM_CH*DATA_W-1:0] probe_in,
    input  logic [SEL_W-1:0]         out_sel,
    input  logic                     slice_sel,
    output logic                     core_en,
    output logic                     halted,
    output logic                     bp_hit,
    output logic [SEL_W-1:0]         bp_idx,
    output logic [DATA_W-1:0]        cycle_cnt,
    output logic [LED_W-1:0]         SYS_leds
);

    dbg_state_e                state_r, next_s;
    logic                      halted_r, bp_hit_r, skip_bp_r;
    logic [SEL_W-1:0]          bp_idx_r;
    logic [DATA_W-1:0]         cycle_cnt_r;
    logic [LED_W-1:0]          leds_r;
    logic [NUM_CH*DATA_W-1:0]  snap_r;
    logic                      raw_match_s, match_s, core_en_s;
    logic [SEL_W-1:0]          raw_idx_s;
    logic [DATA_W-1:0]         chan_s;
    logic [SLICE_MAX_W-1:0]    slice_s;

    sys_debug_ctrl_bp_cmp #(
        .DATA_W (DATA_W),
        .NUM_BP (NUM_BP),
        .SEL_W  (SEL_W)
    ) u_bp_cmp (
        .bp_en   (bp_en),
        .bp_addr (bp_addr),
        .pc_in   (pc_in),
        .match   (raw_match_s),
        .idx     (raw_idx_s)
    );

    // The first RUN cycle after a breakpoint halt must not re-hit the same PC.
    assign match_s = raw_match_s && !skip_bp_r;

    // State register.
    always_ff @(posedge SYS_clk) begin
        if (!SYS_reset) begin
            state_r  <= HALT;
            halted_r <= 1'b1;
        end else begin
            state_r  <= next_s;
            halted_r <= (next_s == HALT);
        end
    end

    // Next-state logic; step beats run, halt beats a breakpoint.
    always_comb begin
        next_s = state_r;
        case (state_r)
            HALT: begin
                if (dbg_step) begin
                    next_s = STEP;
                end else if (dbg_run) begin
                    next_s = RUN;
                end else begin
                    next_s = HALT;
                end
            end
            RUN: begin
                if (dbg_halt || match_s) begin
                    next_s = HALT;
                end else begin
                    next_s = RUN;
                end
            end
            STEP:    next_s = HALT;
            default: next_s = HALT;
        endcase
    end

    // Output logic: the core is gated off in the very cycle a halt or breakpoint is seen.
    always_comb begin
        core_en_s = 1'b0;
        case (state_r)
            STEP:    core_en_s = 1'b1;
            RUN:     core_en_s = !dbg_halt && !match_s;
            HALT:    core_en_s = 1'b0;
            default: core_en_s = 1'b0;
        endcase
    end

    // Breakpoint status, resume mask and halt snapshot.
    always_ff @(posedge SYS_clk) begin
        if (!SYS_reset) begin
            bp_hit_r  <= 1'b0;
            bp_idx_r  <= {SEL_W{1'b0}};
            skip_bp_r <= 1'b0;
            snap_r    <= {(NUM_CH*DATA_W){1'b0}};
        end else begin
            if ((state_r == HALT) && (next_s != HALT)) begin
                bp_hit_r <= 1'b0;
            end else if ((state_r == RUN) && !dbg_halt && match_s) begin
                bp_hit_r <= 1'b1;
                bp_idx_r <= raw_idx_s;
            end else begin
                bp_hit_r <= bp_hit_r;
            end
            if ((state_r == HALT) && (next_s == RUN)) begin
                skip_bp_r <= bp_hit_r;
            end else if (state_r == RUN) begin
                skip_bp_r <= 1'b0;
            end else begin
                skip_bp_r <= skip_bp_r;
            end
            if ((state_r != HALT) && (next_s == HALT)) begin
                snap_r <= probe_in;
            end else begin
                snap_r <= snap_r;
            end
        end
    end

    // Channel mux; selects beyond NUM_CH fall through to zero.
    always_comb begin
        chan_s = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            if (out_sel == SEL_W'(i)) begin
                chan_s = halted_r ? snap_r[i*DATA_W +: DATA_W] : probe_in[i*DATA_W +: DATA_W];
            end else begin
                chan_s = chan_s;
            end
        end
        slice_s = slice_extract(SLICE_MAX_W'(chan_s), slice_sel, LED_W);
    end

    // Saturating executed-cycle counter and registered LED window.
    always_ff @(posedge SYS_clk) begin
        if (!SYS_reset) begin
            cycle_cnt_r <= {DATA_W{1'b0}};
            leds_r      <= {LED_W{1'b0}};
        end else begin
            if (core_en_s && (cycle_cnt_r != {DATA_W{1'b1}})) begin
                cycle_cnt_r <= cycle_cnt_r + DATA_W'(1);
            end else begin
                cycle_cnt_r <= cycle_cnt_r;
            end
            leds_r <= slice_s[LED_W-1:0];
        end
    end

    assign core_en   = core_en_s;
    assign halted    = halted_r;
    assign bp_hit    = bp_hit_r;
    assign bp_idx    = bp_idx_r;
    assign cycle_cnt = cycle_cnt_r;
    assign SYS_leds  = leds_r;

endmodule

// File: tb/tb_sys_debug_ctrl.sv
// Directed scoreboard bench for sys_debug_ctrl with a tiny PC model standing in for the core.
module tb_sys_debug_ctrl;

    localparam int DATA_W = 32;
    localparam int LED_W  = 18;
    localparam int NUM_CH = 8;
    localparam int SEL_W  = 4;
    localparam int NUM_BP = 2;

    logic                     SYS_clk = 1'b0;
    logic                     SYS_reset;
    logic                     dbg_run, dbg_halt, dbg_step;
    logic [NUM_BP-1:0]        bp_en;
    logic [NUM_BP*DATA_W-1:0] bp_addr;
    logic [DATA_W-1:0]        pc;
    logic [NUM_CH*DATA_W-1:0] probe;
    logic [SEL_W-1:0]         out_sel;
    logic                     slice_sel;
    logic                     core_en, halted, bp_hit;
    logic [SEL_W-1:0]         bp_idx;
    logic [DATA_W-1:0]        cycle_cnt;
    logic [LED_W-1:0]         SYS_leds;

    logic                     pc_load;
    logic [DATA_W-1:0]        pc_load_val;
    logic [DATA_W-1:0]        ch3_val;

    string                    tag_q[$];
    logic [31:0]              exp_q[$];
    int                       pass_cnt = 0;
    int                       total_cnt = 0;

    sys_debug_ctrl dut (
        .SYS_clk   (SYS_clk),
        .SYS_reset (SYS_reset),
        .dbg_run   (dbg_run),
        .dbg_halt  (dbg_halt),
        .dbg_step  (dbg_step),
        .bp_en     (bp_en),
        .bp_addr   (bp_addr),
        .pc_in     (pc),
        .probe_in  (probe),
        .out_sel   (out_sel),
        .slice_sel (slice_sel),
        .core_en   (core_en),
        .halted    (halted),
        .bp_hit    (bp_hit),
        .bp_idx    (bp_idx),
        .cycle_cnt (cycle_cnt),
        .SYS_leds  (SYS_leds)
    );

    always #5 SYS_clk = ~SYS_clk;

    // Core model: PC advances by one instruction on every enabled edge.
    always @(posedge SYS_clk) begin
        if (pc_load) begin
            pc <= pc_load_val;
        end else if (core_en) begin
            pc <= pc + 32'd4;
        end
    end

    task automatic expect_val(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check_next(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        total_cnt++;
        if (exp_q.size() == 0) begin
            $error("FAIL scoreboard_empty: got %h required an expected entry", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) pass_cnt++;
            else $error("FAIL %s: got %h required %h", t, obs, e);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge SYS_clk);
    endtask

    initial begin
        SYS_reset = 1'b0; dbg_run = 1'b0; dbg_halt = 1'b0; dbg_step = 1'b0;
        bp_en = 2'b00; bp_addr = '0; probe = '0; out_sel = 4'd0; slice_sel = 1'b0;
        pc_load = 1'b1; pc_load_val = 32'h0;
        ch3_val = 32'hDEAD_BEEF;

        // Reset for two edges.
        expect_val("rst_halted", 32'd1); expect_val("rst_core_en", 32'd0);
        expect_val("rst_leds", 32'd0);   expect_val("rst_cnt", 32'd0);
        expect_val("rst_bp_hit", 32'd0);
        cyc(2);
        SYS_reset = 1'b1; pc_load = 1'b0;
        check_next(halted); check_next(core_en); check_next(SYS_leds);
        check_next(cycle_cnt); check_next(bp_hit);

        // Three single steps, four cycles apart.
        for (int k = 0; k < 3; k++) begin
            dbg_step = 1'b1;
            expect_val("step_core_en", 32'd1); expect_val("step_halted", 32'd0);
            cyc(1);
            dbg_step = 1'b0;
            check_next(core_en); check_next(halted);
            expect_val("step_after_core_en", 32'd0); expect_val("step_after_halted", 32'd1);
            cyc(1);
            check_next(core_en); check_next(halted);
            cyc(2);
        end
        expect_val("step_cnt", 32'd3);
        check_next(cycle_cnt);

        // Breakpoint at 0x10 on both comparators; run from PC 0.
        pc_load = 1'b1; pc_load_val = 32'h0;
        cyc(1);
        pc_load = 1'b0;
        bp_en = 2'b11; bp_addr = {32'h10, 32'h10};
        dbg_run = 1'b1;
        cyc(1);
        dbg_run = 1'b0;
        for (int n = 0; n < 20 && core_en !== 1'b0; n++) cyc(1);
        expect_val("bp_core_en", 32'd0); expect_val("bp_pc", 32'h10);
        check_next(core_en); check_next(pc);
        expect_val("bp_halted", 32'd1); expect_val("bp_hit", 32'd1); expect_val("bp_idx", 32'd0);
        cyc(1);
        check_next(halted); check_next(bp_hit); check_next(bp_idx);

        // Resume: the breakpointed instruction now executes and PC moves on.
        dbg_run = 1'b1;
        expect_val("resume_core_en", 32'd1); expect_val("resume_pc", 32'h10);
        cyc(1);
        dbg_run = 1'b0;
        check_next(core_en); check_next(pc);
        expect_val("resume_next_pc", 32'h14); expect_val("resume_next_core_en", 32'd1);
        cyc(1);
        check_next(pc); check_next(core_en);
        dbg_halt = 1'b1;
        expect_val("halt_halted", 32'd1); expect_val("halt_bp_hit", 32'd0); expect_val("halt_pc", 32'h14);
        cyc(1);
        dbg_halt = 1'b0;
        check_next(halted); check_next(bp_hit); check_next(pc);

        // Only comparator 1 enabled: index reported must be 1.
        bp_en = 2'b10; bp_addr = {32'h20, 32'h14};
        dbg_run = 1'b1;
        cyc(1);
        dbg_run = 1'b0;
        for (int n = 0; n < 20 && halted !== 1'b1; n++) cyc(1);
        expect_val("bp1_pc", 32'h20); expect_val("bp1_hit", 32'd1); expect_val("bp1_idx", 32'd1);
        check_next(pc); check_next(bp_hit); check_next(bp_idx);

        // Run and step together: exactly one step.
        bp_en = 2'b00;
        dbg_run = 1'b1; dbg_step = 1'b1;
        expect_val("rs_core_en", 32'd1); expect_val("rs_halted", 32'd0);
        cyc(1);
        dbg_run = 1'b0; dbg_step = 1'b0;
        check_next(core_en); check_next(halted);
        expect_val("rs_after_halted", 32'd1); expect_val("rs_after_core_en", 32'd0);
        cyc(1);
        check_next(halted); check_next(core_en);

        // Halt command and breakpoint match in the same RUN cycle.
        bp_en = 2'b01; bp_addr = {32'h0, pc};
        dbg_run = 1'b1;
        cyc(1);
        dbg_run = 1'b0; dbg_halt = 1'b1;
        expect_val("hm_core_en", 32'd0);
        check_next(core_en);
        expect_val("hm_halted", 32'd1); expect_val("hm_bp_hit", 32'd0);
        cyc(1);
        dbg_halt = 1'b0;
        check_next(halted); check_next(bp_hit);

        // LED window over a halt snapshot.
        bp_en = 2'b00;
        probe[3*DATA_W +: DATA_W] = ch3_val;
        dbg_step = 1'b1;
        cyc(1);
        dbg_step = 1'b0;
        cyc(1);
        out_sel = 4'd3; slice_sel = 1'b0;
        expect_val("led_lo", {14'd0, ch3_val[17:0]});
        cyc(1);
        check_next(SYS_leds);
        slice_sel = 1'b1;
        expect_val("led_hi", {18'd0, ch3_val[31:18]});
        cyc(1);
        check_next(SYS_leds);
        probe[3*DATA_W +: DATA_W] = 32'h1234_5678;
        expect_val("led_frozen", {18'd0, ch3_val[31:18]});
        cyc(1);
        check_next(SYS_leds);
        out_sel = 4'd9;
        expect_val("led_bad_sel", 32'd0);
        cyc(1);
        check_next(SYS_leds);

        // Running: LEDs follow the live channel.
        out_sel = 4'd3; slice_sel = 1'b0;
        dbg_run = 1'b1;
        cyc(1);
        dbg_run = 1'b0;
        expect_val("led_live", 32'h0000_5678 & 32'h3FFFF | (32'h1234_5678 & 32'h30000));
        cyc(1);
        check_next(SYS_leds);
        dbg_halt = 1'b1;
        cyc(1);
        dbg_halt = 1'b0;

        // Counter saturation.
        force dut.cycle_cnt_r = 32'hFFFF_FFFE;
        cyc(1);
        release dut.cycle_cnt_r;
        dbg_step = 1'b1;
        cyc(1);
        dbg_step = 1'b0;
        expect_val("cnt_max", 32'hFFFF_FFFF);
        cyc(1);
        check_next(cycle_cnt);
        dbg_step = 1'b1;
        cyc(1);
        dbg_step = 1'b0;
        expect_val("cnt_hold", 32'hFFFF_FFFF);
        cyc(1);
        check_next(cycle_cnt);

        // Reset mid-RUN with a concurrent step command.
        bp_en = 2'b11; bp_addr = {32'h0, 32'h0};
        dbg_run = 1'b1;
        cyc(1);
        dbg_run = 1'b0;
        cyc(1);
        SYS_reset = 1'b0; dbg_step = 1'b1;
        expect_val("mr_halted", 32'd1); expect_val("mr_core_en", 32'd0);
        expect_val("mr_cnt", 32'd0);    expect_val("mr_leds", 32'd0);
        expect_val("mr_bp_hit", 32'd0); expect_val("mr_bp_idx", 32'd0);
        cyc(1);
        check_next(halted); check_next(core_en); check_next(cycle_cnt);
        check_next(SYS_leds); check_next(bp_hit); check_next(bp_idx);
        SYS_reset = 1'b1; dbg_step = 1'b0;
        cyc(1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
